// File: rtl/ifu_fq_pkg.sv
// ifu_fq_pkg
//   Shared definitions for the instruction fetch unit with prefetch queue:
//   redirect-kind codes, the default reset PC, the queue entry layout and the
//   redirect target computation.
package ifu_fq_pkg;

    // Redirect kinds carried on npc_sel
    localparam logic [1:0] IFU_SEL_NORM       = 2'd0;
    localparam logic [1:0] IFU_SEL_RELATIVE   = 2'd1;
    localparam logic [1:0] IFU_SEL_IRRELATIVE = 2'd2;
    localparam logic [1:0] IFU_SEL_REGISTER   = 2'd3;

    // Default fetch address after reset
    localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;

    // One prefetch queue entry: 65 bits, {err, pc, inst}
    typedef struct packed {
        logic        err;
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    localparam int FQ_ENTRY_W = $bits(fq_entry_t);

    // Next fetch address for a redirect, relative to the redirecting instruction.
    function automatic logic [31:0] ifu_redir_target(
        input logic [1:0]  sel,
        input logic [31:0] redir_pc,
        input logic [15:0] imm16,
        input logic [25:0] imm26,
        input logic [31:0] reg_target
    );
        logic [31:0]        p4;
        logic signed [31:0] byte_off;
        logic [31:0]        target;
        p4       = redir_pc + 32'd4;
        // imm16 is a signed word offset; scale to bytes
        byte_off = {{14{imm16[15]}}, imm16, 2'b00};
        case (sel)
            IFU_SEL_NORM:       target = p4;
            IFU_SEL_RELATIVE:   target = p4 + byte_off;
            IFU_SEL_IRRELATIVE: target = {p4[31:28], imm26, 2'b00};
            default:            target = reg_target;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/ifu_fq_fifo.sv
// ifu_fq_fifo
//   Synchronous FIFO holding prefetched {err, pc, inst} entries.
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset (pointers/count only)
//     flush  in   synchronous flush; wins over push and pop
//     push   in   write din (taken when not full, or when popping in the same cycle)
//     pop    in   drop the head entry (ignored when empty)
//     din    in   entry to write
//     dout   out  head entry (meaningless when empty)
//     full   out  DEPTH entries held
//     empty  out  no entries held
module ifu_fq_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Control state: DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while counted valid
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ifu_fq.sv
// ifu_fq
//   Instruction fetch unit with a prefetch queue. Fetches sequentially from
//   the instruction ROM "im" (image loaded through the hierarchical name
//   <inst>.im), buffers up to FQ_DEPTH entries and hands them to decode over
//   a valid/ready handshake. A redirect flushes the queue and restarts fetch
//   at the computed target.
//   Ports:
//     clk          in   rising-edge clock
//     reset        in   asynchronous active-low reset
//     redir_valid  in   redirect request this cycle
//     npc_sel      in   redirect kind (IFU_SEL_*)
//     redir_pc     in   PC of the redirecting instruction
//     imm16        in   signed word offset for RELATIVE
//     imm26        in   jump index for IRRELATIVE
//     reg_target   in   target for REGISTER
//     inst_valid   out  queue head valid
//     inst_ready   in   decode accepts head
//     inst         out  head instruction; 0 when invalid or misaligned
//     inst_pc      out  head PC; 0 when invalid
//     inst_err     out  head fetched from a misaligned PC
//     fetch_pc     out  next address to fetch
module ifu_fq
    import ifu_fq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int          IM_WORDS = 1024,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redir_valid,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] redir_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] reg_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_err,
    output logic [31:0] fetch_pc
);

    localparam int IM_AW = $clog2(IM_WORDS);

    logic [31:0]      im [IM_WORDS];
    logic [IM_AW-1:0] im_idx;
    logic             fetch_misaligned;
    fq_entry_t        fetch_entry;
    fq_entry_t        head_entry;
    logic             fq_full;
    logic             fq_empty;
    logic             pop;
    logic             push;

    // Combinational ROM read at the current fetch address
    assign im_idx           = fetch_pc[IM_AW+1:2];
    assign fetch_misaligned = (fetch_pc[1:0] != 2'b00);
    assign fetch_entry.err  = fetch_misaligned;
    assign fetch_entry.pc   = fetch_pc;
    assign fetch_entry.inst = fetch_misaligned ? 32'd0 : im[im_idx];

    assign pop  = inst_valid && inst_ready;
    // A redirect cycle neither pushes nor pops; the flush discards everything
    assign push = !redir_valid && (!fq_full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
        end else if (redir_valid) begin
            fetch_pc <= ifu_redir_target(npc_sel, redir_pc, imm16, imm26, reg_target);
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    ifu_fq_fifo #(
        .WIDTH (FQ_ENTRY_W),
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .flush (redir_valid),
        .push  (push),
        .pop   (pop && !redir_valid),
        .din   (fetch_entry),
        .dout  (head_entry),
        .full  (fq_full),
        .empty (fq_empty)
    );

    // Head outputs are forced to zero whenever nothing valid is presented
    assign inst_valid = !fq_empty;
    assign inst_err   = inst_valid && head_entry.err;
    assign inst_pc    = inst_valid ? head_entry.pc : 32'd0;
    assign inst       = (inst_valid && !head_entry.err) ? head_entry.inst : 32'd0;

endmodule

// File: tb/tb_ifu_fq.sv
// tb_ifu_fq
//   Directed bench for ifu_fq. ROM word k holds 32'h1000_0000 + k,
//   RESET_PC = 32'h3000, FQ_DEPTH = 4. Accepted heads are compared against a
//   queue of expected {pc, inst, err}; state after resets and redirects is
//   checked directly.
module tb_ifu_fq;
    import ifu_fq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        redir_valid;
    logic [1:0]  npc_sel;
    logic [31:0] redir_pc;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] reg_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic [31:0] fetch_pc;

    always #5 clk = ~clk;

    ifu_fq #(
        .RESET_PC (32'h0000_3000),
        .IM_WORDS (1024),
        .FQ_DEPTH (4)
    ) i (
        .clk         (clk),
        .reset       (reset),
        .redir_valid (redir_valid),
        .npc_sel     (npc_sel),
        .redir_pc    (redir_pc),
        .imm16       (imm16),
        .imm26       (imm26),
        .reg_target  (reg_target),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_err    (inst_err),
        .fetch_pc    (fetch_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expected entry for a fetch at pc, from the ROM preload pattern
    function automatic exp_t model(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.err  = (pc[1:0] != 2'b00);
        e.inst = e.err ? 32'd0 : (32'h1000_0000 + {22'd0, pc[11:2]});
        return e;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: one handshake per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (reset === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1 && redir_valid === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h inst %h, expected no transfer (t=%0t)",
                         inst_pc, inst, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check32("sb_pc",   inst_pc, mon_e.pc);
                check32("sb_inst", inst,    mon_e.inst);
                check32("sb_err",  {31'd0, inst_err}, {31'd0, mon_e.err});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_stream(input logic [31:0] pc0, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(model(pc0 + 32'(4 * k)));
    endtask

    // Accept n heads back to back starting at pc0
    task automatic take(input logic [31:0] pc0, input int n);
        expect_stream(pc0, n);
        inst_ready = 1'b1;
        repeat (n) step();
        inst_ready = 1'b0;
    endtask

    // One-cycle redirect, then check the bubble cycle and the target at head
    task automatic redir(input logic [1:0] sel, input logic [31:0] rpc, input logic [15:0] i16,
                         input logic [25:0] i26, input logic [31:0] rt, input logic rdy,
                         input logic [31:0] exp_target);
        npc_sel     = sel;
        redir_pc    = rpc;
        imm16       = i16;
        imm26       = i26;
        reg_target  = rt;
        inst_ready  = rdy;
        redir_valid = 1'b1;
        step();
        redir_valid = 1'b0;
        inst_ready  = 1'b0;
        check32("redir_bubble_valid", {31'd0, inst_valid}, 32'd0);
        check32("redir_fetch_pc", fetch_pc, exp_target);
        step();
        check32("redir_head_pc", inst_pc, exp_target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        redir_valid = 1'b0;
        npc_sel     = IFU_SEL_NORM;
        redir_pc    = '0;
        imm16       = '0;
        imm26       = '0;
        reg_target  = '0;
        inst_ready  = 1'b0;
        for (int k = 0; k < 1024; k++) i.im[k] = 32'h1000_0000 + 32'(k);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check32("rst_valid",    {31'd0, inst_valid}, 32'd0);
        check32("rst_inst",     inst, 32'd0);
        check32("rst_inst_pc",  inst_pc, 32'd0);
        check32("rst_err",      {31'd0, inst_err}, 32'd0);
        check32("rst_fetch_pc", fetch_pc, 32'h0000_3000);

        // 1: release with decode stalled; queue fills and holds
        reset = 1'b1;
        step();
        check32("t1_valid",    {31'd0, inst_valid}, 32'd1);
        check32("t1_pc",       inst_pc, 32'h0000_3000);
        check32("t1_inst",     inst, 32'h1000_0000);
        check32("t1_fetch_pc", fetch_pc, 32'h0000_3004);
        repeat (5) step();
        check32("t1_full_fetch_pc", fetch_pc, 32'h0000_3010);
        check32("t1_full_head",     inst_pc, 32'h0000_3000);

        // 2: streaming, stall with a full queue, resume
        take(32'h0000_3000, 8);
        repeat (3) step();
        check32("t2_stall_head",     inst_pc, 32'h0000_3020);
        check32("t2_stall_fetch_pc", fetch_pc, 32'h0000_3030);
        take(32'h0000_3020, 4);

        // 3: relative branches forward and backward
        redir(IFU_SEL_RELATIVE, 32'h0000_3004, 16'h0001, 26'd0, 32'd0, 1'b0, 32'h0000_300c);
        check32("t3_inst", inst, 32'h1000_0003);
        take(32'h0000_300c, 2);
        redir(IFU_SEL_RELATIVE, 32'h0000_3004, 16'hffff, 26'd0, 32'd0, 1'b0, 32'h0000_3004);
        take(32'h0000_3004, 2);

        // 4: jump, jump-register, misaligned jump-register
        redir(IFU_SEL_IRRELATIVE, 32'h0000_3008, 16'd0, 26'h0001234, 32'd0, 1'b0, 32'h0000_48d0);
        take(32'h0000_48d0, 2);
        redir(IFU_SEL_REGISTER, 32'h0000_3000, 16'd0, 26'd0, 32'h0000_3008, 1'b0, 32'h0000_3008);
        take(32'h0000_3008, 1);
        redir(IFU_SEL_REGISTER, 32'h0000_3000, 16'd0, 26'd0, 32'h0000_3002, 1'b0, 32'h0000_3002);
        check32("t4_err",      {31'd0, inst_err}, 32'd1);
        check32("t4_err_inst", inst, 32'd0);
        take(32'h0000_3002, 2);

        // 5: redirect coinciding with a pop on a full queue holding 3000-300c
        redir(IFU_SEL_REGISTER, 32'h0000_3000, 16'd0, 26'd0, 32'h0000_3000, 1'b0, 32'h0000_3000);
        repeat (4) step();
        check32("t5_full_fetch_pc", fetch_pc, 32'h0000_3010);
        redir(IFU_SEL_REGISTER, 32'h0000_3000, 16'd0, 26'd0, 32'h0000_3100, 1'b1, 32'h0000_3100);
        take(32'h0000_3100, 4);

        // Redirect into an empty queue right after another redirect
        npc_sel     = IFU_SEL_REGISTER;
        reg_target  = 32'h0000_3200;
        redir_valid = 1'b1;
        step();
        redir(IFU_SEL_NORM, 32'h0000_3000, 16'd0, 26'd0, 32'd0, 1'b1, 32'h0000_3004);
        take(32'h0000_3004, 2);

        // 6: asynchronous reset mid-stream
        redir(IFU_SEL_REGISTER, 32'h0000_3000, 16'd0, 26'd0, 32'h0000_3300, 1'b0, 32'h0000_3300);
        expect_stream(32'h0000_3300, 2);
        inst_ready = 1'b1;
        repeat (2) step();
        #2;
        reset = 1'b0;
        #1;
        check32("t6_valid",    {31'd0, inst_valid}, 32'd0);
        check32("t6_inst_pc",  inst_pc, 32'd0);
        check32("t6_fetch_pc", fetch_pc, 32'h0000_3000);
        @(posedge clk);
        #1;
        inst_ready = 1'b0;
        reset      = 1'b1;
        step();
        check32("t6_restart_pc", inst_pc, 32'h0000_3000);
        take(32'h0000_3000, 4);

        repeat (3) step();
        check32("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
